// File: rtl/spi_req_arbiter_if.sv
// Bus bundle between the two client FSMs, the burst arbiter and one spi_master.
// Handshake: spi_data_valid is a one-cycle launch pulse that carries spi_data_send. spi_recv_completed
// is a one-cycle pulse returning spi_data_recv. tx_take, rx_valid and done are one-cycle pulses aimed
// at the owning channel. req is a level and is only looked at while the arbiter is idle.
interface spi_req_arbiter_if #(
   parameter int LEN_W = 8
);
   logic [1:0]       req;
   logic [LEN_W-1:0] len0;
   logic [LEN_W-1:0] len1;
   logic [7:0]       tx0;
   logic [7:0]       tx1;
   logic [1:0]       tx_take;
   logic [7:0]       rx_data;
   logic [1:0]       rx_valid;
   logic [1:0]       done;
   logic             err;
   logic [1:0]       grant;
   logic             busy;
   logic [7:0]       spi_data_send;
   logic             spi_data_valid;
   logic [7:0]       spi_data_recv;
   logic             spi_recv_completed;
   logic [2:0]       dbg_state;

   modport master (
      input  req, len0, len1, tx0, tx1, spi_data_recv, spi_recv_completed,
      output tx_take, rx_data, rx_valid, done, err, grant, busy,
             spi_data_send, spi_data_valid, dbg_state
   );

   modport slave (
      output req, len0, len1, tx0, tx1, spi_data_recv, spi_recv_completed,
      input  tx_take, rx_data, rx_valid, done, err, grant, busy,
             spi_data_send, spi_data_valid, dbg_state
   );
endinterface

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter that lends one spi_master to two channels for whole multi-byte bursts,
// with an idle gap between bytes and a per-byte watchdog that aborts a stuck transfer.
module spi_req_arbiter #(
   parameter int LEN_W      = 8,
   parameter int GAP_CYCLES = 2,
   parameter int TIMEOUT    = 1024
) (
   input  logic              clk,
   input  logic              rst,
   spi_req_arbiter_if.master bus
);
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LAUNCH = 3'd1,
      S_WAIT   = 3'd2,
      S_GAP    = 3'd3,
      S_FIN    = 3'd4
   } state_t;

   localparam int WW = $clog2(TIMEOUT + 1);
   localparam int GW = $clog2(GAP_CYCLES + 2);
   localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   state_t           state;
   logic             own;
   logic             last_grant;
   logic [LEN_W-1:0] rem;
   logic [WW-1:0]    wd;
   logic [GW-1:0]    gap_cnt;
   logic             win;
   logic [1:0]       win_oh;
   logic [1:0]       own_oh;
   logic [LEN_W-1:0] win_len;

   // On a tie the channel that did not own the previous burst wins.
   always_comb begin
      win = 1'b0;
      if (bus.req == 2'b11) win = ~last_grant;
      else if (bus.req[1]) win = 1'b1;
   end

   assign win_oh        = win ? 2'b10 : 2'b01;
   assign own_oh        = own ? 2'b10 : 2'b01;
   assign win_len       = win ? bus.len1 : bus.len0;
   assign bus.dbg_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= S_IDLE;
         own                <= 1'b0;
         last_grant         <= 1'b1;
         rem                <= '0;
         wd                 <= '0;
         gap_cnt            <= '0;
         bus.tx_take        <= 2'b00;
         bus.rx_data        <= 8'h00;
         bus.rx_valid       <= 2'b00;
         bus.done           <= 2'b00;
         bus.err            <= 1'b0;
         bus.grant          <= 2'b00;
         bus.busy           <= 1'b0;
         bus.spi_data_send  <= 8'h00;
         bus.spi_data_valid <= 1'b0;
      end else begin
         bus.spi_data_valid <= 1'b0;
         bus.tx_take        <= 2'b00;
         bus.rx_valid       <= 2'b00;
         bus.done           <= 2'b00;
         bus.err            <= 1'b0;
         case (state)
            S_IDLE: begin
               bus.grant <= 2'b00;
               if (bus.req != 2'b00) begin
                  own        <= win;
                  last_grant <= win;
                  bus.grant  <= win_oh;
                  bus.busy   <= 1'b1;
                  rem        <= win_len;
                  if (win_len == '0) begin
                     state    <= S_FIN;
                     bus.done <= win_oh;
                  end else begin
                     state <= S_LAUNCH;
                  end
               end
            end
            S_LAUNCH: begin
               bus.spi_data_send  <= own ? bus.tx1 : bus.tx0;
               bus.spi_data_valid <= 1'b1;
               bus.tx_take        <= own_oh;
               wd                 <= '0;
               state              <= S_WAIT;
            end
            S_WAIT: begin
               if (bus.spi_recv_completed) begin
                  bus.rx_data  <= bus.spi_data_recv;
                  bus.rx_valid <= own_oh;
                  rem          <= rem - 1'b1;
                  if (rem == LEN_W'(1)) begin
                     state    <= S_FIN;
                     bus.done <= own_oh;
                  end else if (GAP_CYCLES == 0) begin
                     state <= S_LAUNCH;
                  end else begin
                     state   <= S_GAP;
                     gap_cnt <= '0;
                  end
               end else if (wd == WD_LAST) begin
                  // done/err land exactly TIMEOUT cycles after the launch pulse.
                  state    <= S_FIN;
                  bus.done <= own_oh;
                  bus.err  <= 1'b1;
               end else begin
                  wd <= wd + 1'b1;
               end
            end
            S_GAP: begin
               if (gap_cnt == GAP_LAST) state <= S_LAUNCH;
               else gap_cnt <= gap_cnt + 1'b1;
            end
            S_FIN: begin
               // grant stays up one more cycle so the owner is still visible after done.
               bus.busy <= 1'b0;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_req_arbiter.sv
// Bench for spi_req_arbiter: two instances (gap 2 and gap 0, watchdog 16) with echoing spi_master
// models; launches, received bytes and done pulses of instance a are scoreboarded as events.
module tb_spi_req_arbiter;
   localparam int SPI_LAT = 4;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   int   viol     = 0;
   logic [11:0] exp_q[$];
   logic [11:0] obs_q[$];
   logic [7:0]  tx0_q[$];
   logic [7:0]  tx1_q[$];
   logic [7:0]  txb_q[$];
   logic        slave_en_a = 1'b1;
   logic [7:0]  echo_a     = 8'h5A;
   int          scnt_a     = 0;
   int          scnt_b     = 0;

   spi_req_arbiter_if #(.LEN_W(8)) ia ();
   spi_req_arbiter_if #(.LEN_W(8)) ib ();

   spi_req_arbiter #(.LEN_W(8), .GAP_CYCLES(2), .TIMEOUT(16)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ia)
   );

   spi_req_arbiter #(.LEN_W(8), .GAP_CYCLES(0), .TIMEOUT(16)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ib)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [11:0] ev_tx(input logic [7:0] d);
      return {4'b0000, d};
   endfunction

   function automatic logic [11:0] ev_rx(input logic [1:0] ch, input logic [7:0] d);
      return {2'b01, ch, d};
   endfunction

   function automatic logic [11:0] ev_done(input logic [1:0] ch, input logic e);
      return {2'b10, ch, 7'd0, e};
   endfunction

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Monitor: records instance a output events and one-hot violations.
   initial begin
      forever begin
         @(negedge clk);
         if (ia.spi_data_valid) obs_q.push_back(ev_tx(ia.spi_data_send));
         if (ia.rx_valid != 2'b00) obs_q.push_back(ev_rx(ia.rx_valid, ia.rx_data));
         if (ia.done != 2'b00) obs_q.push_back(ev_done(ia.done, ia.err));
         if ($countones(ia.grant) > 1 || $countones(ia.rx_valid) > 1 ||
             $countones(ia.done) > 1 || (ia.err && ia.done == 2'b00)) viol++;
      end
   end

   // Client models: present the head of each byte queue, advance on tx_take.
   initial begin
      logic [7:0] t;
      ia.tx0 = 8'h00; ia.tx1 = 8'h00; ib.tx0 = 8'h00; ib.tx1 = 8'h00;
      forever begin
         @(negedge clk);
         if (ia.tx_take[0] && tx0_q.size() > 0) t = tx0_q.pop_front();
         if (ia.tx_take[1] && tx1_q.size() > 0) t = tx1_q.pop_front();
         if (ib.tx_take[0] && txb_q.size() > 0) t = txb_q.pop_front();
         ia.tx0 = (tx0_q.size() > 0) ? tx0_q[0] : 8'h00;
         ia.tx1 = (tx1_q.size() > 0) ? tx1_q[0] : 8'h00;
         ib.tx0 = (txb_q.size() > 0) ? txb_q[0] : 8'h00;
      end
   end

   // spi_master models: answer each launch SPI_LAT cycles later.
   initial begin
      ia.spi_recv_completed = 1'b0; ia.spi_data_recv = 8'h00;
      ib.spi_recv_completed = 1'b0; ib.spi_data_recv = 8'h00;
      forever begin
         @(negedge clk);
         ia.spi_recv_completed = 1'b0;
         ib.spi_recv_completed = 1'b0;
         if (scnt_a > 0) begin
            scnt_a--;
            if (scnt_a == 0) begin ia.spi_recv_completed = 1'b1; ia.spi_data_recv = echo_a; end
         end
         if (scnt_b > 0) begin
            scnt_b--;
            if (scnt_b == 0) begin ib.spi_recv_completed = 1'b1; ib.spi_data_recv = 8'h5A; end
         end
         if (ia.spi_data_valid && slave_en_a) scnt_a = SPI_LAT;
         if (ib.spi_data_valid) scnt_b = SPI_LAT;
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      ia.req = 2'b00; ia.len0 = 8'd0; ia.len1 = 8'd0;
      ib.req = 2'b00; ib.len0 = 8'd0; ib.len1 = 8'd0;
      repeat (3) tick();
      checks++;
      if ({ia.grant, ia.busy, ia.done, ia.err, ia.rx_valid, ia.tx_take, ia.spi_data_valid} !== 11'd0) begin
         failures++;
         $display("FAIL reset_ctrl_a got=%b required=0", {ia.grant, ia.busy, ia.done, ia.err, ia.rx_valid, ia.tx_take, ia.spi_data_valid});
      end
      checks++;
      if ({ia.spi_data_send, ia.rx_data} !== 16'h0000) begin
         failures++; $display("FAIL reset_data_a got=%h required=0000", {ia.spi_data_send, ia.rx_data});
      end
      checks++;
      if (ia.dbg_state !== 3'd0) begin
         failures++; $display("FAIL reset_state_a got=%0d required=0", ia.dbg_state);
      end
      checks++;
      if ({ib.grant, ib.busy, ib.done, ib.err, ib.spi_data_valid} !== 7'd0) begin
         failures++; $display("FAIL reset_ctrl_b got=%b required=0", {ib.grant, ib.busy, ib.done, ib.err, ib.spi_data_valid});
      end
      rst = 1'b0;
      tick();
      obs_q.delete();
   endtask

   task automatic test_single_burst();
      int n;
      logic [11:0] e, o;
      logic [7:0] b [3];
      b = '{8'hA5, 8'h3C, 8'hFF};
      echo_a = 8'h5A;
      for (int i = 0; i < 3; i++) begin
         tx0_q.push_back(b[i]);
         exp_q.push_back(ev_tx(b[i]));
         exp_q.push_back(ev_rx(2'b01, 8'h5A));
      end
      exp_q.push_back(ev_done(2'b01, 1'b0));
      tick();
      ia.len0 = 8'd3; ia.req = 2'b01;
      n = 0;
      while (ia.done == 2'b00 && n < 200) begin tick(); if (ia.busy) ia.req = 2'b00; n++; end
      checks++;
      if (n >= 200) begin failures++; $display("FAIL single_burst_timeout got=no_done required=done"); end
      repeat (3) tick();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 12'hFFF;
         checks++;
         if (o !== e) begin failures++; $display("FAIL single_burst_event got=%h required=%h", o, e); end
      end
      checks++;
      if (obs_q.size() != 0) begin
         failures++; $display("FAIL single_burst_extra got=%0d required=0", obs_q.size()); obs_q.delete();
      end
   endtask

   task automatic test_round_robin();
      int n, nd;
      logic [11:0] e, o;
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      obs_q.delete();
      echo_a = 8'h96;
      tx0_q.push_back(8'h11); tx0_q.push_back(8'h33);
      tx1_q.push_back(8'h22); tx1_q.push_back(8'h44);
      exp_q.push_back(ev_tx(8'h11)); exp_q.push_back(ev_rx(2'b01, 8'h96)); exp_q.push_back(ev_done(2'b01, 1'b0));
      exp_q.push_back(ev_tx(8'h22)); exp_q.push_back(ev_rx(2'b10, 8'h96)); exp_q.push_back(ev_done(2'b10, 1'b0));
      exp_q.push_back(ev_tx(8'h33)); exp_q.push_back(ev_rx(2'b01, 8'h96)); exp_q.push_back(ev_done(2'b01, 1'b0));
      exp_q.push_back(ev_tx(8'h44)); exp_q.push_back(ev_rx(2'b10, 8'h96)); exp_q.push_back(ev_done(2'b10, 1'b0));
      tick();
      ia.len0 = 8'd1; ia.len1 = 8'd1; ia.req = 2'b11;
      n = 0; nd = 0;
      while (nd < 4 && n < 400) begin
         tick(); n++;
         if (ia.done != 2'b00) begin
            nd++;
            if (nd == 3) ia.req = 2'b10;
            if (nd == 4) ia.req = 2'b00;
         end
      end
      checks++;
      if (nd != 4) begin failures++; $display("FAIL round_robin_bursts got=%0d required=4", nd); end
      ia.req = 2'b00;
      repeat (3) tick();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 12'hFFF;
         checks++;
         if (o !== e) begin failures++; $display("FAIL round_robin_event got=%h required=%h", o, e); end
      end
      checks++;
      if (obs_q.size() != 0) begin
         failures++; $display("FAIL round_robin_extra got=%0d required=0", obs_q.size()); obs_q.delete();
      end
   endtask

   task automatic test_zero_len();
      int gc, vc;
      logic [11:0] e, o;
      exp_q.push_back(ev_done(2'b10, 1'b0));
      ia.len1 = 8'd0; ia.req = 2'b10;
      gc = 0; vc = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (ia.busy) ia.req = 2'b00;
         if (ia.grant == 2'b10) gc++;
         if (ia.spi_data_valid) vc++;
      end
      checks++;
      if (gc != 2) begin failures++; $display("FAIL zero_len_grant_cycles got=%0d required=2", gc); end
      checks++;
      if (vc != 0) begin failures++; $display("FAIL zero_len_launches got=%0d required=0", vc); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 12'hFFF;
         checks++;
         if (o !== e) begin failures++; $display("FAIL zero_len_event got=%h required=%h", o, e); end
      end
      checks++;
      if (obs_q.size() != 0) begin
         failures++; $display("FAIL zero_len_extra got=%0d required=0", obs_q.size()); obs_q.delete();
      end
   endtask

   task automatic test_timeout();
      int n, lc, dc;
      logic [11:0] e, o;
      slave_en_a = 1'b0;
      tx0_q.push_back(8'h77); tx0_q.push_back(8'h88);
      exp_q.push_back(ev_tx(8'h77));
      exp_q.push_back(ev_done(2'b01, 1'b1));
      tick();
      ia.len0 = 8'd2; ia.req = 2'b01;
      lc = -1; dc = -1; n = 0;
      while (dc < 0 && n < 100) begin
         tick(); n++;
         if (ia.busy) ia.req = 2'b00;
         if (ia.spi_data_valid && lc < 0) lc = n;
         if (ia.done != 2'b00) dc = n;
      end
      checks++;
      if (dc < 0 || lc < 0 || dc - lc != 16) begin
         failures++; $display("FAIL timeout_latency got=%0d required=16", dc - lc);
      end
      slave_en_a = 1'b1;
      tx0_q.delete();
      repeat (3) tick();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 12'hFFF;
         checks++;
         if (o !== e) begin failures++; $display("FAIL timeout_event got=%h required=%h", o, e); end
      end
      checks++;
      if (obs_q.size() != 0) begin
         failures++; $display("FAIL timeout_extra got=%0d required=0", obs_q.size()); obs_q.delete();
      end
   endtask

   task automatic test_gap_spacing();
      int la[4], lb[4];
      int na, nb, n;
      logic da, db;
      logic [11:0] e, o;
      la = '{default: 0}; lb = '{default: 0};
      echo_a = 8'h5A;
      for (int i = 0; i < 4; i++) begin
         tx0_q.push_back(8'hC1 + 8'(i));
         txb_q.push_back(8'hD1 + 8'(i));
         exp_q.push_back(ev_tx(8'hC1 + 8'(i)));
         exp_q.push_back(ev_rx(2'b01, 8'h5A));
      end
      exp_q.push_back(ev_done(2'b01, 1'b0));
      tick();
      ia.len0 = 8'd4; ib.len0 = 8'd4; ia.req = 2'b01; ib.req = 2'b01;
      na = 0; nb = 0; da = 1'b0; db = 1'b0; n = 0;
      while (!(da && db) && n < 300) begin
         tick(); n++;
         if (ia.busy) ia.req = 2'b00;
         if (ib.busy) ib.req = 2'b00;
         if (ia.spi_data_valid && na < 4) begin la[na] = n; na++; end
         if (ib.spi_data_valid && nb < 4) begin lb[nb] = n; nb++; end
         if (ia.done != 2'b00) da = 1'b1;
         if (ib.done != 2'b00) db = 1'b1;
      end
      checks++;
      if (!(da && db)) begin failures++; $display("FAIL gap_done got=%b%b required=11", da, db); end
      checks++;
      if (nb != 4) begin failures++; $display("FAIL gap_b_launches got=%0d required=4", nb); end
      for (int k = 1; k < 4; k++) begin
         checks++;
         if ((la[k] - la[k-1]) - (lb[k] - lb[k-1]) != 2) begin
            failures++;
            $display("FAIL gap_spacing_%0d got=%0d required=2", k, (la[k] - la[k-1]) - (lb[k] - lb[k-1]));
         end
      end
      repeat (3) tick();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 12'hFFF;
         checks++;
         if (o !== e) begin failures++; $display("FAIL gap_event got=%h required=%h", o, e); end
      end
      checks++;
      if (obs_q.size() != 0) begin
         failures++; $display("FAIL gap_extra got=%0d required=0", obs_q.size()); obs_q.delete();
      end
   endtask

   task automatic test_reset_mid_burst();
      int n, vc;
      logic [11:0] e, o;
      echo_a = 8'h3E;
      tx0_q.push_back(8'hA1); tx0_q.push_back(8'hA2); tx0_q.push_back(8'hA3);
      exp_q.push_back(ev_tx(8'hA1));
      exp_q.push_back(ev_rx(2'b01, 8'h3E));
      exp_q.push_back(ev_tx(8'hA2));
      tick();
      ia.len0 = 8'd3; ia.req = 2'b01;
      n = 0; vc = 0;
      while (vc < 2 && n < 200) begin
         tick(); n++;
         if (ia.busy) ia.req = 2'b00;
         if (ia.spi_data_valid) vc++;
      end
      rst = 1'b1;
      tick();
      checks++;
      if ({ia.grant, ia.busy, ia.done, ia.err, ia.rx_valid, ia.tx_take, ia.spi_data_valid,
           ia.spi_data_send, ia.rx_data, ia.dbg_state} !== 30'd0) begin
         failures++; $display("FAIL reset_mid_outputs got=%h required=0", {ia.grant, ia.busy, ia.done, ia.err,
            ia.rx_valid, ia.tx_take, ia.spi_data_valid, ia.spi_data_send, ia.rx_data, ia.dbg_state});
      end
      rst = 1'b0;
      tx0_q.delete();
      repeat (8) tick();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 12'hFFF;
         checks++;
         if (o !== e) begin failures++; $display("FAIL reset_mid_event got=%h required=%h", o, e); end
      end
      checks++;
      if (obs_q.size() != 0) begin
         failures++; $display("FAIL reset_mid_extra got=%0d required=0", obs_q.size()); obs_q.delete();
      end
      tx0_q.push_back(8'h5E);
      exp_q.push_back(ev_tx(8'h5E));
      exp_q.push_back(ev_rx(2'b01, 8'h3E));
      exp_q.push_back(ev_done(2'b01, 1'b0));
      tick();
      ia.len0 = 8'd1; ia.req = 2'b01;
      n = 0;
      while (ia.done == 2'b00 && n < 200) begin tick(); if (ia.busy) ia.req = 2'b00; n++; end
      checks++;
      if (n >= 200) begin failures++; $display("FAIL reset_mid_recover got=no_done required=done"); end
      repeat (3) tick();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 12'hFFF;
         checks++;
         if (o !== e) begin failures++; $display("FAIL reset_recover_event got=%h required=%h", o, e); end
      end
      checks++;
      if (obs_q.size() != 0) begin
         failures++; $display("FAIL reset_recover_extra got=%0d required=0", obs_q.size()); obs_q.delete();
      end
   endtask

   task automatic test_onehot();
      checks++;
      if (viol != 0) begin failures++; $display("FAIL onehot_violations got=%0d required=0", viol); end
   endtask

   initial begin
      test_reset();
      test_single_burst();
      test_round_robin();
      test_zero_len();
      test_timeout();
      test_gap_spacing();
      test_reset_mid_burst();
      test_onehot();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
